// File: rtl/free_ptr_pool.sv
// Free-address allocator for the data table RAM.
// Self-initialises to hold every address in ascending order, hands them out
// through a show-ahead output register and accepts returned addresses.
// Optional double-free detection: define FREE_PTR_DOUBLE_FREE_CHECK_EN.
module free_ptr_pool #(
  parameter int unsigned A_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               reinit_i,
  output logic               init_done_o,
  input  logic [A_WIDTH-1:0] add_free_ptr_i,
  input  logic               add_free_ptr_en_i,
  output logic [A_WIDTH-1:0] next_free_ptr_o,
  output logic               next_free_ptr_val_o,
  input  logic               next_free_ptr_rd_ack_i,
  output logic [A_WIDTH:0]   free_cnt_o,
  output logic               overflow_o,
  output logic               underflow_o,
  output logic               double_free_o
);

  localparam int unsigned DEPTH = 2**A_WIDTH;
  localparam int unsigned CW    = A_WIDTH + 1;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]         state, state_n;
  logic [A_WIDTH-1:0] init_cnt, init_cnt_n;
  logic [A_WIDTH-1:0] wr_ptr, wr_ptr_n;
  logic [A_WIDTH-1:0] rd_ptr, rd_ptr_n;
  logic [CW-1:0]      fifo_cnt, fifo_cnt_n;
  logic [A_WIDTH-1:0] mem [DEPTH];

  logic               mem_we;
  logic [A_WIDTH-1:0] mem_wd;

  logic               done_n, val_n, ovf_n, unf_n, dbl_n;
  logic [A_WIDTH-1:0] ptr_n;
  logic [CW-1:0]      cnt_n;

  logic pop, push, load, full, dbl_hit;

`ifdef FREE_PTR_DOUBLE_FREE_CHECK_EN
  logic [DEPTH-1:0] free_map, free_map_n;
  // A pointer being popped this very cycle is no longer free, so re-adding it is legal.
  assign dbl_hit = free_map[add_free_ptr_i] &&
                   !(pop && (next_free_ptr_o == add_free_ptr_i));
`else
  assign dbl_hit = 1'b0;
`endif

  assign pop  = next_free_ptr_rd_ack_i && next_free_ptr_val_o;
  assign full = (free_cnt_o == CW'(DEPTH));
  assign push = (state == ST_READY) && add_free_ptr_en_i && !dbl_hit && (!full || pop);
  assign load = (state == ST_READY) && (!next_free_ptr_val_o || pop) && (fifo_cnt != '0);

  // Next-state and next-output computation.
  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    wr_ptr_n   = wr_ptr;
    rd_ptr_n   = rd_ptr;
    fifo_cnt_n = fifo_cnt;
    done_n     = init_done_o;
    val_n      = next_free_ptr_val_o;
    ptr_n      = next_free_ptr_o;
    cnt_n      = free_cnt_o;
    ovf_n      = 1'b0;
    unf_n      = 1'b0;
    dbl_n      = 1'b0;
    mem_we     = 1'b0;
    mem_wd     = add_free_ptr_i;
`ifdef FREE_PTR_DOUBLE_FREE_CHECK_EN
    free_map_n = free_map;
`endif
    if (reinit_i) begin
      state_n    = ST_INIT;
      init_cnt_n = '0;
      wr_ptr_n   = '0;
      rd_ptr_n   = '0;
      fifo_cnt_n = '0;
      done_n     = 1'b0;
      val_n      = 1'b0;
      ptr_n      = '0;
      cnt_n      = '0;
`ifdef FREE_PTR_DOUBLE_FREE_CHECK_EN
      free_map_n = '0;
`endif
    end else if (state == ST_INIT) begin
      mem_we     = 1'b1;
      mem_wd     = init_cnt;
      wr_ptr_n   = wr_ptr + A_WIDTH'(1);
      fifo_cnt_n = fifo_cnt + CW'(1);
      cnt_n      = free_cnt_o + CW'(1);
      init_cnt_n = init_cnt + A_WIDTH'(1);
      ovf_n      = add_free_ptr_en_i;
      unf_n      = next_free_ptr_rd_ack_i;
      if (init_cnt == A_WIDTH'(DEPTH - 1)) begin
        state_n = ST_READY;
        done_n  = 1'b1;
`ifdef FREE_PTR_DOUBLE_FREE_CHECK_EN
        free_map_n = '1;
`endif
      end
    end else begin
      unf_n      = next_free_ptr_rd_ack_i && !next_free_ptr_val_o;
      dbl_n      = add_free_ptr_en_i && dbl_hit;
      ovf_n      = add_free_ptr_en_i && !dbl_hit && !push;
      fifo_cnt_n = fifo_cnt + CW'(push) - CW'(load);
      cnt_n      = free_cnt_o + CW'(push) - CW'(pop);
      if (push) begin
        mem_we   = 1'b1;
        wr_ptr_n = wr_ptr + A_WIDTH'(1);
      end
      if (load) begin
        ptr_n    = mem[rd_ptr];
        rd_ptr_n = rd_ptr + A_WIDTH'(1);
        val_n    = 1'b1;
      end else if (pop) begin
        val_n = 1'b0;
      end
`ifdef FREE_PTR_DOUBLE_FREE_CHECK_EN
      if (pop)  free_map_n[next_free_ptr_o] = 1'b0;
      if (push) free_map_n[add_free_ptr_i]  = 1'b1;
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state               <= ST_INIT;
      init_cnt            <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      fifo_cnt            <= '0;
      init_done_o         <= 1'b0;
      next_free_ptr_val_o <= 1'b0;
      next_free_ptr_o     <= '0;
      free_cnt_o          <= '0;
      overflow_o          <= 1'b0;
      underflow_o         <= 1'b0;
    end else begin
      state               <= state_n;
      init_cnt            <= init_cnt_n;
      wr_ptr              <= wr_ptr_n;
      rd_ptr              <= rd_ptr_n;
      fifo_cnt            <= fifo_cnt_n;
      init_done_o         <= done_n;
      next_free_ptr_val_o <= val_n;
      next_free_ptr_o     <= ptr_n;
      free_cnt_o          <= cnt_n;
      overflow_o          <= ovf_n;
      underflow_o         <= unf_n;
    end
  end

  // FIFO storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[wr_ptr] <= mem_wd;
  end

`ifdef FREE_PTR_DOUBLE_FREE_CHECK_EN
  // Free bitmap and double-free pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      free_map      <= '0;
      double_free_o <= 1'b0;
    end else begin
      free_map      <= free_map_n;
      double_free_o <= dbl_n;
    end
  end
`else
  assign double_free_o = 1'b0;
  logic unused_dbl;
  assign unused_dbl = dbl_n;
`endif

endmodule

// File: tb/tb_free_ptr_pool.sv
// Directed self-checking bench for free_ptr_pool with A_WIDTH=4.
module tb_free_ptr_pool;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst, reinit, add_en, rd_ack;
  logic [AW-1:0] add_ptr;
  logic          init_done, val, ovf, unf, dbl;
  logic [AW-1:0] ptr;
  logic [AW:0]   cnt;

  int n_checks = 0;
  int n_fail   = 0;

  free_ptr_pool #(.A_WIDTH(AW)) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .reinit_i               (reinit),
    .init_done_o            (init_done),
    .add_free_ptr_i         (add_ptr),
    .add_free_ptr_en_i      (add_en),
    .next_free_ptr_o        (ptr),
    .next_free_ptr_val_o    (val),
    .next_free_ptr_rd_ack_i (rd_ack),
    .free_cnt_o             (cnt),
    .overflow_o             (ovf),
    .underflow_o            (unf),
    .double_free_o          (dbl)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; reinit = 1'b0; add_en = 1'b0; rd_ack = 1'b0; add_ptr = '0;
    tick(); tick();
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done: got %0b want 0", init_done); end
    n_checks++; if (val !== 1'b0) begin n_fail++; $display("FAIL rst_val: got %0b want 0", val); end
    n_checks++; if (cnt !== 5'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", cnt); end
    n_checks++; if ({ovf, unf, dbl} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses: got %03b want 000", {ovf, unf, dbl}); end
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if (init_done !== 1'b0 || cnt !== 5'd15) begin n_fail++; $display("FAIL init_c15: got done=%0b cnt=%0d want 0/15", init_done, cnt); end
    tick();
    n_checks++; if (init_done !== 1'b1 || cnt !== 5'd16 || val !== 1'b0) begin n_fail++; $display("FAIL init_c16: got done=%0b cnt=%0d val=%0b want 1/16/0", init_done, cnt, val); end
    tick();
    n_checks++; if (val !== 1'b1 || ptr !== 4'd0 || cnt !== 5'd16) begin n_fail++; $display("FAIL init_c17: got val=%0b ptr=%0d cnt=%0d want 1/0/16", val, ptr, cnt); end
  endtask

  task automatic test_back_to_back;
    rd_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (val !== 1'b1 || ptr !== AW'(i) || cnt !== 5'(16 - i)) begin
        n_fail++; $display("FAIL b2b_pop%0d: got val=%0b ptr=%0d cnt=%0d want 1/%0d/%0d", i, val, ptr, cnt, i, 16 - i);
      end
      tick();
    end
    n_checks++; if (val !== 1'b0 || cnt !== 5'd0 || unf !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got val=%0b cnt=%0d unf=%0b want 0/0/0", val, cnt, unf); end
    tick();
    rd_ack = 1'b0;
    n_checks++; if (unf !== 1'b1 || cnt !== 5'd0) begin n_fail++; $display("FAIL underflow: got unf=%0b cnt=%0d want 1/0", unf, cnt); end
    tick();
    n_checks++; if (unf !== 1'b0) begin n_fail++; $display("FAIL underflow_pulse: got %0b want 0", unf); end
  endtask

  task automatic test_empty_push;
    add_ptr = 4'd9; add_en = 1'b1;
    tick();
    add_en = 1'b0;
    n_checks++; if (cnt !== 5'd1 || val !== 1'b0) begin n_fail++; $display("FAIL push_n1: got cnt=%0d val=%0b want 1/0", cnt, val); end
    tick();
    n_checks++; if (val !== 1'b1 || ptr !== 4'd9) begin n_fail++; $display("FAIL push_n2: got val=%0b ptr=%0d want 1/9", val, ptr); end
  endtask

  task automatic test_full;
    logic [AW-1:0] fp;
    logic [AW-1:0] exp_seq [16];
    int k;
`ifdef FREE_PTR_DOUBLE_FREE_CHECK_EN
    fp = 4'd9;
`else
    fp = 4'd3;
`endif
    k = 0;
    for (int p = 0; p < 16; p++) begin
      if (p != 9) begin
        add_ptr = AW'(p); add_en = 1'b1; tick();
        exp_seq[k] = AW'(p); k++;
      end
    end
    exp_seq[15] = fp;
    add_en = 1'b0;
    n_checks++; if (cnt !== 5'd16) begin n_fail++; $display("FAIL fill_cnt: got %0d want 16", cnt); end
    add_ptr = 4'd3; add_en = 1'b1; tick(); add_en = 1'b0;
`ifdef FREE_PTR_DOUBLE_FREE_CHECK_EN
    n_checks++; if (dbl !== 1'b1 || ovf !== 1'b0) begin n_fail++; $display("FAIL full_add: got dbl=%0b ovf=%0b want 1/0", dbl, ovf); end
`else
    n_checks++; if (ovf !== 1'b1 || dbl !== 1'b0) begin n_fail++; $display("FAIL full_add: got ovf=%0b dbl=%0b want 1/0", ovf, dbl); end
`endif
    n_checks++; if (cnt !== 5'd16) begin n_fail++; $display("FAIL full_add_cnt: got %0d want 16", cnt); end
    tick();
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse: got %0b want 0", ovf); end
    add_ptr = fp; add_en = 1'b1; rd_ack = 1'b1; tick(); add_en = 1'b0; rd_ack = 1'b0;
    n_checks++; if (cnt !== 5'd16 || ovf !== 1'b0 || dbl !== 1'b0) begin n_fail++; $display("FAIL full_pushpop: got cnt=%0d ovf=%0b dbl=%0b want 16/0/0", cnt, ovf, dbl); end
    rd_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (val !== 1'b1 || ptr !== exp_seq[i]) begin
        n_fail++; $display("FAIL order%0d: got val=%0b ptr=%0d want 1/%0d", i, val, ptr, exp_seq[i]);
      end
      tick();
    end
    rd_ack = 1'b0;
    n_checks++; if (val !== 1'b0 || cnt !== 5'd0) begin n_fail++; $display("FAIL order_end: got val=%0b cnt=%0d want 0/0", val, cnt); end
  endtask

  task automatic test_reinit;
    reinit = 1'b1; tick(); reinit = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    n_checks++; if (val !== 1'b1 || cnt !== 5'd16) begin n_fail++; $display("FAIL reinit1_ready: got val=%0b cnt=%0d want 1/16", val, cnt); end
    rd_ack = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    rd_ack = 1'b0;
    n_checks++; if (cnt !== 5'd10 || ptr !== 4'd6) begin n_fail++; $display("FAIL mid_alloc: got cnt=%0d ptr=%0d want 10/6", cnt, ptr); end
    reinit = 1'b1; add_en = 1'b1; add_ptr = 4'd5; tick();
    reinit = 1'b0; add_en = 1'b0;
    n_checks++; if (val !== 1'b0 || cnt !== 5'd0 || init_done !== 1'b0) begin n_fail++; $display("FAIL reinit_next: got val=%0b cnt=%0d done=%0b want 0/0/0", val, cnt, init_done); end
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if (cnt !== 5'd15 || init_done !== 1'b0) begin n_fail++; $display("FAIL reinit_c15: got cnt=%0d done=%0b want 15/0", cnt, init_done); end
    tick();
    n_checks++; if (init_done !== 1'b1 || cnt !== 5'd16) begin n_fail++; $display("FAIL reinit_c16: got done=%0b cnt=%0d want 1/16", init_done, cnt); end
    tick();
    n_checks++; if (val !== 1'b1 || ptr !== 4'd0) begin n_fail++; $display("FAIL reinit_c17: got val=%0b ptr=%0d want 1/0", val, ptr); end
  endtask

  task automatic test_double_free;
    rd_ack = 1'b1; tick(); tick(); rd_ack = 1'b0;
    n_checks++; if (cnt !== 5'd14 || ptr !== 4'd2) begin n_fail++; $display("FAIL df_pop: got cnt=%0d ptr=%0d want 14/2", cnt, ptr); end
    add_ptr = 4'd0; add_en = 1'b1; tick();
    n_checks++; if (cnt !== 5'd15 || dbl !== 1'b0) begin n_fail++; $display("FAIL df_first: got cnt=%0d dbl=%0b want 15/0", cnt, dbl); end
    tick(); add_en = 1'b0;
`ifdef FREE_PTR_DOUBLE_FREE_CHECK_EN
    n_checks++; if (dbl !== 1'b1 || cnt !== 5'd15) begin n_fail++; $display("FAIL df_second: got dbl=%0b cnt=%0d want 1/15", dbl, cnt); end
`else
    n_checks++; if (dbl !== 1'b0 || cnt !== 5'd16) begin n_fail++; $display("FAIL df_second: got dbl=%0b cnt=%0d want 0/16", dbl, cnt); end
`endif
    tick();
    n_checks++; if (dbl !== 1'b0) begin n_fail++; $display("FAIL df_pulse: got %0b want 0", dbl); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_empty_push();
    test_full();
    test_reinit();
    test_double_free();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
